stream_sync_fifo_pkt: RTL and testbench

Single-clock AXI-stream-style FIFO. It is parametrised in data width and depth, and carries a last flag, a fill level and an almost-full flag. An optional store-and-forward packet mode presents a packet downstream only once it is completely buffered. It sits between same-clock pipeline stages, for example an image line buffer feeding a SPI/packetiser. There it replaces the dual-clock FIFO plus FWFT interface pair where no CDC is needed.

---
 rtl/stream_fifo_pkt_gate.sv | 56 +++++
 rtl/stream_sync_fifo_pkt.sv | 85 ++++++++
 tb/tb_stream_sync_fifo_pkt.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_pkt_gate.sv
// Output-valid gating for the stream FIFO: counts buffered end-of-packet beats
// and holds back the head until a whole packet (or a full buffer) is present.
module stream_fifo_pkt_gate #(
   parameter int AW       = 4,
   parameter bit PKT_MODE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  logic push_last,
   input  logic pop,
   input  logic pop_last,
   input  logic empty,
   input  logic full,
   output logic m_valid
);

   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_ZERO = '0;

   logic [AW:0] pkt_cnt;
   logic        cut_through;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt     <= CNT_ZERO;
         cut_through <= 1'b0;
      end else if (flush) begin
         pkt_cnt     <= CNT_ZERO;
         cut_through <= 1'b0;
      end else begin
         case ({push & push_last, pop & pop_last})
            2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
            2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
            default: pkt_cnt <= pkt_cnt;
         endcase
         // An oversize packet fills the buffer with no last stored; stream it
         // through until its last beat leaves, otherwise nothing could drain.
         if (pop && pop_last)
            cut_through <= 1'b0;
         else if (full && (pkt_cnt == CNT_ZERO))
            cut_through <= 1'b1;
      end
   end

   always_comb begin
      // NOTE: assigning a default first keeps this block free of inferred latches.
      m_valid = 1'b0;
      if (PKT_MODE)
         m_valid = !empty && ((pkt_cnt != CNT_ZERO) || full || cut_through);
      else
         m_valid = !empty;
   end

endmodule

// File: rtl/stream_sync_fifo_pkt.sv
// Single-clock ready/valid FIFO with last flag, fill level, almost-full and an
// optional store-and-forward packet mode.
module stream_sync_fifo_pkt #(
   parameter int DW        = 8,
   parameter int AW        = 4,
   parameter int AF_THRESH = (1 << AW) - 2,
   parameter bit PKT_MODE  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic [DW-1:0] stream_s_data_i,
   input  logic          stream_s_last_i,
   input  logic          stream_s_valid_i,
   output logic          stream_s_ready_o,
   output logic [DW-1:0] stream_m_data_o,
   output logic          stream_m_last_o,
   output logic          stream_m_valid_o,
   input  logic          stream_m_ready_i,
   output logic [AW:0]   level_o,
   output logic          almost_full_o
);

   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] AF_LVL  = AF_THRESH[AW:0];

   logic [DW:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // No full-bypass: a pop while full frees the slot only for the next cycle.
   assign stream_s_ready_o = !full && !flush_i && !rst;
   assign push             = stream_s_valid_i && stream_s_ready_o;
   assign pop              = stream_m_valid_o && stream_m_ready_i && !flush_i;

   assign {stream_m_last_o, stream_m_data_o} = mem[rd_ptr[AW-1:0]];

   assign level_o       = wr_ptr - rd_ptr;
   assign almost_full_o = (level_o >= AF_LVL);

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_i) begin
         rd_ptr <= wr_ptr;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage has no reset; contents are only observed behind a valid pointer.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {stream_s_last_i, stream_s_data_i};
   end

   stream_fifo_pkt_gate #(
      .AW       (AW),
      .PKT_MODE (PKT_MODE)
   ) u_gate (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .push      (push),
      .push_last (stream_s_last_i),
      .pop       (pop),
      .pop_last  (stream_m_last_o),
      .empty     (empty),
      .full      (full),
      .m_valid   (stream_m_valid_o)
   );

endmodule

// File: tb/tb_stream_sync_fifo_pkt.sv
// Directed bench: streaming instance (AW=2) and two packet-mode instances (AW=3, AW=2).
module tb_stream_sync_fifo_pkt;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // a: streaming, AW=2
   logic       a_flush = 0, a_s_last = 0, a_s_valid = 0, a_m_ready = 0;
   logic [7:0] a_s_data = '0;
   logic       a_s_ready, a_m_last, a_m_valid, a_af;
   logic [7:0] a_m_data;
   logic [2:0] a_level;
   // b: packet mode, AW=3
   logic       b_flush = 0, b_s_last = 0, b_s_valid = 0, b_m_ready = 0;
   logic [7:0] b_s_data = '0;
   logic       b_s_ready, b_m_last, b_m_valid, b_af;
   logic [7:0] b_m_data;
   logic [3:0] b_level;
   // c: packet mode, AW=2
   logic       c_flush = 0, c_s_last = 0, c_s_valid = 0, c_m_ready = 0;
   logic [7:0] c_s_data = '0;
   logic       c_s_ready, c_m_last, c_m_valid, c_af;
   logic [7:0] c_m_data;
   logic [2:0] c_level;

   stream_sync_fifo_pkt #(.DW(8), .AW(2), .PKT_MODE(1'b0)) u_a (
      .clk(clk), .rst(rst), .flush_i(a_flush),
      .stream_s_data_i(a_s_data), .stream_s_last_i(a_s_last),
      .stream_s_valid_i(a_s_valid), .stream_s_ready_o(a_s_ready),
      .stream_m_data_o(a_m_data), .stream_m_last_o(a_m_last),
      .stream_m_valid_o(a_m_valid), .stream_m_ready_i(a_m_ready),
      .level_o(a_level), .almost_full_o(a_af));

   stream_sync_fifo_pkt #(.DW(8), .AW(3), .PKT_MODE(1'b1)) u_b (
      .clk(clk), .rst(rst), .flush_i(b_flush),
      .stream_s_data_i(b_s_data), .stream_s_last_i(b_s_last),
      .stream_s_valid_i(b_s_valid), .stream_s_ready_o(b_s_ready),
      .stream_m_data_o(b_m_data), .stream_m_last_o(b_m_last),
      .stream_m_valid_o(b_m_valid), .stream_m_ready_i(b_m_ready),
      .level_o(b_level), .almost_full_o(b_af));

   stream_sync_fifo_pkt #(.DW(8), .AW(2), .PKT_MODE(1'b1)) u_c (
      .clk(clk), .rst(rst), .flush_i(c_flush),
      .stream_s_data_i(c_s_data), .stream_s_last_i(c_s_last),
      .stream_s_valid_i(c_s_valid), .stream_s_ready_o(c_s_ready),
      .stream_m_data_o(c_m_data), .stream_m_last_o(c_m_last),
      .stream_m_valid_o(c_m_valid), .stream_m_ready_i(c_m_ready),
      .level_o(c_level), .almost_full_o(c_af));

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [7:0] a_in  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] a_out [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
   logic [7:0] b_pkt [3] = '{8'hA1, 8'hA2, 8'hA3};
   logic [7:0] c_pkt [6] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};

   initial begin
      int sent;
      int got;

      // reset state, sampled between edges
      #12;
      check("rst_s_ready", a_s_ready, 0);
      check("rst_m_valid", a_m_valid, 0);
      check("rst_level",   a_level,   0);
      check("rst_af",      a_af,      0);
      #6 rst = 1'b0;
      tick();
      check("post_rst_s_ready", a_s_ready, 1);

      // streaming fill to full
      a_s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_s_data = a_in[i];
         tick();
         check("fill_level", a_level, i + 1);
         check("fill_af",    a_af,    (i + 1) >= 2);
      end
      check("full_s_ready", a_s_ready, 0);
      check("full_m_valid", a_m_valid, 1);
      check("full_head",    a_m_data,  8'h11);

      // full with push and pop offered together: one pop, no push
      a_s_data  = 8'h55;
      a_m_ready = 1'b1;
      #1;
      check("both_level_pre", a_level, 4);
      tick();
      check("both_level_post", a_level, 3);
      check("both_head",       a_m_data, 8'h22);
      a_m_ready = 1'b0;
      #1;
      check("refill_s_ready", a_s_ready, 1);
      tick();
      check("refill_level", a_level, 4);

      // drain in order
      a_s_valid = 1'b0;
      a_m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", a_m_valid, 1);
         check("drain_data",  a_m_data,  a_out[i]);
         tick();
      end
      check("drain_empty_valid", a_m_valid, 0);
      check("drain_empty_level", a_level,   0);
      a_m_ready = 1'b0;

      // packet mode: held until last beat is stored
      b_s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_s_data = b_pkt[i];
         b_s_last = (i == 2);
         tick();
         check("pkt_gate_valid", b_m_valid, i == 2);
      end
      b_s_valid = 1'b0;
      b_s_last  = 1'b0;
      b_m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("pkt_out_data", b_m_data, b_pkt[i]);
         check("pkt_out_last", b_m_last, i == 2);
         tick();
      end
      check("pkt_out_done", b_m_valid, 0);
      b_m_ready = 1'b0;

      // flush with 3 stored entries (one complete packet among them)
      b_s_valid = 1'b1;
      b_s_data = 8'hB1; b_s_last = 1'b1; tick();
      b_s_data = 8'hB2; b_s_last = 1'b0; tick();
      b_s_data = 8'hB3; tick();
      check("pre_flush_level", b_level,   3);
      check("pre_flush_valid", b_m_valid, 1);
      b_flush   = 1'b1;
      b_s_data  = 8'hC0;
      b_s_last  = 1'b1;
      b_m_ready = 1'b1;
      #1;
      check("flush_s_ready", b_s_ready, 0);
      tick();
      b_flush = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0; b_s_last = 1'b0;
      check("flush_level", b_level,   0);
      check("flush_valid", b_m_valid, 0);
      b_s_valid = 1'b1; b_s_data = 8'hD0; tick();
      b_s_valid = 1'b0;
      check("flush_cnt_level", b_level,   1);
      check("flush_cnt_clear", b_m_valid, 0);
      b_s_valid = 1'b1; b_s_data = 8'hD1; b_s_last = 1'b1; tick();
      b_s_valid = 1'b0; b_s_last = 1'b0;
      check("post_flush_valid", b_m_valid, 1);
      check("post_flush_head",  b_m_data,  8'hD0);
      b_m_ready = 1'b1;
      tick(); tick();
      b_m_ready = 1'b0;
      check("post_flush_drain", b_level, 0);

      // oversize packet: fills, cut-through fallback, then gating resumes
      c_m_ready = 1'b1;
      c_s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c_s_data = c_pkt[i];
         tick();
         check("big_gate_valid", c_m_valid, i == 3);
      end
      check("big_full_level", c_level, 4);
      sent = 4;
      got  = 0;
      for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
         c_s_valid = (sent < 6);
         c_s_data  = (sent < 6) ? c_pkt[sent] : 8'h00;
         c_s_last  = (sent == 5);
         #1;
         if (c_m_valid) begin
            check("big_data", c_m_data, c_pkt[got]);
            check("big_last", c_m_last, got == 5);
            got++;
         end
         if (c_s_valid && c_s_ready) sent++;
         tick();
      end
      check("big_count", got, 6);
      c_s_valid = 1'b0;
      c_s_last  = 1'b0;
      check("big_end_level", c_level, 0);
      c_s_valid = 1'b1; c_s_data = 8'hF0; tick();
      c_s_valid = 1'b0;
      check("big_regate_level", c_level,   1);
      check("big_regate_valid", c_m_valid, 0);

      // asynchronous reset mid-packet
      a_s_valid = 1'b1;
      a_s_data = 8'h61; tick();
      a_s_data = 8'h62; tick();
      a_s_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_s_ready", a_s_ready, 0);
      check("arst_m_valid", a_m_valid, 0);
      check("arst_level",   a_level,   0);
      #2 rst = 1'b0;
      tick();
      a_s_valid = 1'b1; a_s_data = 8'h77; tick();
      a_s_valid = 1'b0;
      check("arst_fresh_valid", a_m_valid, 1);
      check("arst_fresh_data",  a_m_data,  8'h77);
      check("arst_fresh_level", a_level,   1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
